pipe_stage_regs: RTL

- Front-end pipeline register bank that consumes the hazard controls: PC register, IF/ID register and ID/EX register of the 5-stage MIPS core.
- Receives stall_if / stall_id / flash_ex from the hazard unit and applies hold and bubble semantics.
- Tracks a valid bit per stage so later stages and the bench can tell real instructions from bubbles.

---
 rtl/pipe_stage_regs_if.sv | 71 +++++++
 rtl/pipe_stage_regs.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_regs_if.sv
// pipe_stage_regs_if: signal bundle between the hazard unit / ID stage and the
// front-end pipeline register bank.
// The master side drives fetch, decode and hazard controls and observes the
// pipeline registers. The slave side is the register bank.
// Optional macro PIPE_PERF_CNT_EN adds the stall_cnt / bubble_cnt counters.
interface pipe_stage_regs_if #(
  parameter int unsigned WIDTH = 32
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
);

  // hazard controls
  logic             stall_if;
  logic             stall_id;
  logic             flash_ex;
  logic             pcsrc_id;
  logic [WIDTH-1:0] pcbranch_id;

  // fetch and decode inputs
  logic [WIDTH-1:0] instr_if;
  logic [WIDTH-1:0] rd1_id;
  logic [WIDTH-1:0] rd2_id;
  logic [WIDTH-1:0] signimm_id;
  logic [4:0]       rs_id;
  logic [4:0]       rt_id;
  logic [4:0]       rd_id;
  logic [8:0]       ctrl_id;

  // pipeline register contents
  logic [WIDTH-1:0] pc_if;
  logic [WIDTH-1:0] pcplus4_if;
  logic [WIDTH-1:0] instr_id;
  logic [WIDTH-1:0] pcplus4_id;
  logic             valid_id;
  logic [WIDTH-1:0] rd1_ex;
  logic [WIDTH-1:0] rd2_ex;
  logic [WIDTH-1:0] signimm_ex;
  logic [4:0]       rs_ex;
  logic [4:0]       rt_ex;
  logic [4:0]       rd_ex;
  logic [8:0]       ctrl_ex;
  logic             valid_ex;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;
`endif

  modport master (
`ifdef PIPE_PERF_CNT_EN
    input  stall_cnt, bubble_cnt,
`endif
    output stall_if, stall_id, flash_ex, pcsrc_id, pcbranch_id,
    output instr_if, rd1_id, rd2_id, signimm_id, rs_id, rt_id, rd_id, ctrl_id,
    input  pc_if, pcplus4_if, instr_id, pcplus4_id, valid_id,
    input  rd1_ex, rd2_ex, signimm_ex, rs_ex, rt_ex, rd_ex, ctrl_ex, valid_ex
  );

  modport slave (
`ifdef PIPE_PERF_CNT_EN
    output stall_cnt, bubble_cnt,
`endif
    input  stall_if, stall_id, flash_ex, pcsrc_id, pcbranch_id,
    input  instr_if, rd1_id, rd2_id, signimm_id, rs_id, rt_id, rd_id, ctrl_id,
    output pc_if, pcplus4_if, instr_id, pcplus4_id, valid_id,
    output rd1_ex, rd2_ex, signimm_ex, rs_ex, rt_ex, rd_ex, ctrl_ex, valid_ex
  );

endinterface

// File: rtl/pipe_stage_regs.sv
// pipe_stage_regs: PC, IF/ID and ID/EX registers of the 5-stage MIPS core.
// Applies hazard-unit hold (stall_if / stall_id), branch clear (pcsrc_id) and
// EX bubble (flash_ex) semantics and tracks a valid bit per stage.
// Optional macro PIPE_PERF_CNT_EN adds saturating stall / bubble counters.
module pipe_stage_regs #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int unsigned      CNT_W    = 16
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_stage_regs_if.slave   bus
);

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] FOUR_W = {{(WIDTH-3){1'b0}}, 3'd4};

  // PC stage
  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] pcplus4_s;
  logic [WIDTH-1:0] pc_nxt_s;

  // IF/ID stage
  logic [WIDTH-1:0] instr_id_r;
  logic [WIDTH-1:0] pcplus4_id_r;
  logic             valid_id_r;
  logic [WIDTH-1:0] instr_id_nxt_s;
  logic [WIDTH-1:0] pcplus4_id_nxt_s;
  logic             valid_id_nxt_s;
  logic             ifid_clear_s;

  // ID/EX stage
  logic [WIDTH-1:0] rd1_ex_r;
  logic [WIDTH-1:0] rd2_ex_r;
  logic [WIDTH-1:0] signimm_ex_r;
  logic [4:0]       rs_ex_r;
  logic [4:0]       rt_ex_r;
  logic [4:0]       rd_ex_r;
  logic [8:0]       ctrl_ex_r;
  logic             valid_ex_r;
  logic [WIDTH-1:0] rd1_ex_nxt_s;
  logic [WIDTH-1:0] rd2_ex_nxt_s;
  logic [WIDTH-1:0] signimm_ex_nxt_s;
  logic [4:0]       rs_ex_nxt_s;
  logic [4:0]       rt_ex_nxt_s;
  logic [4:0]       rd_ex_nxt_s;
  logic [8:0]       ctrl_ex_nxt_s;
  logic             valid_ex_nxt_s;

  // Next PC: branch target wins over sequential fetch; PC only moves when enabled.
  always_comb begin
    pcplus4_s = pc_r + FOUR_W;
    pc_nxt_s  = pc_r;
    if (bus.stall_if) begin
      if (bus.pcsrc_id) begin
        pc_nxt_s = bus.pcbranch_id;
      end else begin
        pc_nxt_s = pcplus4_s;
      end
    end else begin
      pc_nxt_s = pc_r;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_nxt_s;
    end
  end

  // IF/ID next state: a taken branch clears only when the stage is enabled, so
  // a clear requested during a stall waits for the release with pcsrc_id held.
  always_comb begin
    ifid_clear_s     = 1'b0;
    instr_id_nxt_s   = instr_id_r;
    pcplus4_id_nxt_s = pcplus4_id_r;
    valid_id_nxt_s   = valid_id_r;
    case ({bus.pcsrc_id, bus.stall_id})
      2'b11: begin
        ifid_clear_s     = 1'b1;
        instr_id_nxt_s   = ZERO_W;
        pcplus4_id_nxt_s = ZERO_W;
        valid_id_nxt_s   = 1'b0;
      end
      2'b01: begin
        instr_id_nxt_s   = bus.instr_if;
        pcplus4_id_nxt_s = pcplus4_s;
        valid_id_nxt_s   = 1'b1;
      end
      default: begin
        instr_id_nxt_s   = instr_id_r;
        pcplus4_id_nxt_s = pcplus4_id_r;
        valid_id_nxt_s   = valid_id_r;
      end
    endcase
  end

  // IF/ID register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_id_r   <= ZERO_W;
      pcplus4_id_r <= ZERO_W;
      valid_id_r   <= 1'b0;
    end else begin
      instr_id_r   <= instr_id_nxt_s;
      pcplus4_id_r <= pcplus4_id_nxt_s;
      valid_id_r   <= valid_id_nxt_s;
    end
  end

  // ID/EX next state: never held; either a bubble or whatever ID decodes now.
  always_comb begin
    rd1_ex_nxt_s     = ZERO_W;
    rd2_ex_nxt_s     = ZERO_W;
    signimm_ex_nxt_s = ZERO_W;
    rs_ex_nxt_s      = 5'd0;
    rt_ex_nxt_s      = 5'd0;
    rd_ex_nxt_s      = 5'd0;
    ctrl_ex_nxt_s    = 9'd0;
    valid_ex_nxt_s   = 1'b0;
    if (bus.flash_ex) begin
      valid_ex_nxt_s = 1'b0;
    end else begin
      rd1_ex_nxt_s     = bus.rd1_id;
      rd2_ex_nxt_s     = bus.rd2_id;
      signimm_ex_nxt_s = bus.signimm_id;
      rs_ex_nxt_s      = bus.rs_id;
      rt_ex_nxt_s      = bus.rt_id;
      rd_ex_nxt_s      = bus.rd_id;
      ctrl_ex_nxt_s    = bus.ctrl_id;
      valid_ex_nxt_s   = valid_id_r;
    end
  end

  // ID/EX register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_ex_r     <= ZERO_W;
      rd2_ex_r     <= ZERO_W;
      signimm_ex_r <= ZERO_W;
      rs_ex_r      <= 5'd0;
      rt_ex_r      <= 5'd0;
      rd_ex_r      <= 5'd0;
      ctrl_ex_r    <= 9'd0;
      valid_ex_r   <= 1'b0;
    end else begin
      rd1_ex_r     <= rd1_ex_nxt_s;
      rd2_ex_r     <= rd2_ex_nxt_s;
      signimm_ex_r <= signimm_ex_nxt_s;
      rs_ex_r      <= rs_ex_nxt_s;
      rt_ex_r      <= rt_ex_nxt_s;
      rd_ex_r      <= rd_ex_nxt_s;
      ctrl_ex_r    <= ctrl_ex_nxt_s;
      valid_ex_r   <= valid_ex_nxt_s;
    end
  end

  assign bus.pc_if      = pc_r;
  assign bus.pcplus4_if = pcplus4_s;
  assign bus.instr_id   = instr_id_r;
  assign bus.pcplus4_id = pcplus4_id_r;
  assign bus.valid_id   = valid_id_r;
  assign bus.rd1_ex     = rd1_ex_r;
  assign bus.rd2_ex     = rd2_ex_r;
  assign bus.signimm_ex = signimm_ex_r;
  assign bus.rs_ex      = rs_ex_r;
  assign bus.rt_ex      = rt_ex_r;
  assign bus.rd_ex      = rd_ex_r;
  assign bus.ctrl_ex    = ctrl_ex_r;
  assign bus.valid_ex   = valid_ex_r;

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] bubble_cnt_r;
  logic [CNT_W-1:0] stall_cnt_nxt_s;
  logic [CNT_W-1:0] bubble_cnt_nxt_s;

  // Counter next values: count held-decode cycles and injected bubbles, sticking at all-ones.
  always_comb begin
    stall_cnt_nxt_s  = stall_cnt_r;
    bubble_cnt_nxt_s = bubble_cnt_r;
    if (!bus.stall_id && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_nxt_s = stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_nxt_s = stall_cnt_r;
    end
    if ((bus.flash_ex || ifid_clear_s) && (bubble_cnt_r != CNT_MAX)) begin
      bubble_cnt_nxt_s = bubble_cnt_r + CNT_ONE;
    end else begin
      bubble_cnt_nxt_s = bubble_cnt_r;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r  <= {CNT_W{1'b0}};
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_r  <= stall_cnt_nxt_s;
      bubble_cnt_r <= bubble_cnt_nxt_s;
    end
  end

  assign bus.stall_cnt  = stall_cnt_r;
  assign bus.bubble_cnt = bubble_cnt_r;
`endif

endmodule
